// File: rtl/multiply.sv
// multiply: sequential shift-and-add multiplier.
//
// One multiplier bit is consumed per clock, LSB first, so a WIDTH-bit
// multiply always takes exactly WIDTH BUSY cycles. The final product is
// loaded into P only on the last BUSY edge; P never shows a partial sum.
//
// Optional feature: define MULT_SIGNED_EN to treat A and B as two's
// complement. The core still multiplies magnitudes; the sign of A^B is
// applied when P is loaded, so latency is identical in both builds.
module multiply #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 ok,
    output logic                 busy,
    output logic                 err
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [WIDTH-1:0]  mplier_q, mplier_d; // multiplier, shifted right each step
    logic [PW-1:0]     acc_q, acc_d;       // running partial product
    logic [CNT_W-1:0]  cnt_q, cnt_d;       // BUSY iteration index
    logic [PW-1:0]     p_q, p_d;
    logic              err_q, err_d;
    logic              neg_q, neg_d;       // result sign, only ever set in signed build

    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     prod_final;
    logic              last_iter;

    // Magnitude of an operand: two's complement negate in the signed build.
    // The most negative value maps to itself, which is its correct unsigned
    // magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef MULT_SIGNED_EN
        return v[WIDTH-1] ? -v : v;
`else
        return v;
`endif
    endfunction

    // Sign of the product, derived from the operand sign bits.
    function automatic logic product_sign(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
`ifdef MULT_SIGNED_EN
        return a[WIDTH-1] ^ b[WIDTH-1];
`else
        return 1'b0 & (a[0] ^ b[0]);
`endif
    endfunction

    // Apply the result sign to the unsigned magnitude product.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                 input logic          neg);
        return neg ? -mag : mag;
    endfunction

    // Product does not fit in WIDTH bits (unsigned or signed sense).
    function automatic logic overflow(input logic [PW-1:0] p);
`ifdef MULT_SIGNED_EN
        return p[PW-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
`else
        return |p[PW-1:WIDTH];
`endif
    endfunction

    assign last_iter  = (cnt_q == LAST_CNT);
    // Full-width add: the accumulator can never overflow.
    assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_final = apply_sign(acc_sum, neg_q);

    // State register, asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)     state_d = BUSY;
            BUSY: if (last_iter) state_d = DONE;
            DONE: if (!start)    state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state_q == BUSY);
        ok   = (state_q == DONE);
    end

    // Datapath next values: capture in IDLE, one shift-add step per BUSY cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        err_d    = err_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(A)};
                    mplier_d = magnitude(B);
                    acc_d    = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    neg_d    = product_sign(A, B);
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    p_d   = prod_final;
                    err_d = overflow(prod_final);
                    cnt_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears everything so an aborted multiply
    // leaves no trace on P.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            err_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            err_q    <= err_d;
            neg_q    <= neg_d;
        end
    end

    assign P   = p_q;
    assign err = err_q;

endmodule

// File: tb/tb_multiply.sv
// tb_multiply: table-driven bench for the sequential multiplier, plus
// hand-written sequences for reset-held start and mid-BUSY reset.
module tb_multiply;

    localparam int W = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [2*W-1:0]  P;
    logic            ok;
    logic            busy;
    logic            err;

    int total;
    int passed;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        logic           e;
    } vec_t;

    vec_t vt[$];

    multiply #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .ok    (ok),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, wanted finish)");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Run one multiply; must be called between clock edges.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_p, input logic exp_e, input string nm);
        logic [2*W-1:0] p_prev;
        int n;
        bit stable;
        A = a;
        B = b;
        start = 1'b1;
        p_prev = P;
        @(posedge clk); #1;
        chk({nm, "_busy_on_capture"}, busy, 1);
        chk({nm, "_ok_clear_on_capture"}, ok, 0);
        chk({nm, "_err_clear_on_capture"}, err, 0);
        n = 0;
        stable = 1'b1;
        while (!ok && n < 100) begin
            // Operand changes during BUSY must not affect the result.
            A = $urandom;
            B = $urandom;
            @(posedge clk); #1;
            n++;
            if (!ok && P !== p_prev) stable = 1'b0;
        end
        chk({nm, "_latency"}, n, W);
        chk({nm, "_P"}, P, exp_p);
        chk({nm, "_err"}, err, exp_e);
        chk({nm, "_P_stable_in_busy"}, stable, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_ok_held_with_start"}, ok, 1);
        chk({nm, "_no_retrigger"}, busy, 0);
        start = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_ok_falls"}, ok, 0);
        chk({nm, "_P_held_idle"}, P, exp_p);
        chk({nm, "_err_held_idle"}, err, exp_e);
    endtask

    initial begin
        total  = 0;
        passed = 0;

`ifdef MULT_SIGNED_EN
        vt.push_back('{32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 1'b0});
        vt.push_back('{32'h4000_0000, 32'd4,        64'h0000_0001_0000_0000, 1'b1});
        vt.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0});
        vt.push_back('{32'd0,         32'h1234_5678, 64'h0,                   1'b0});
        vt.push_back('{32'd3,         32'd5,        64'd15,                  1'b0});
        vt.push_back('{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1});
        vt.push_back('{32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000, 1'b0});
        vt.push_back('{32'h7FFF_FFFF, 32'd2,        64'h0000_0000_FFFF_FFFE, 1'b1});
        vt.push_back('{32'd7,         32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1, 1'b0});
`else
        vt.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1});
        vt.push_back('{32'd0,         32'h1234_5678, 64'h0,                   1'b0});
        vt.push_back('{32'd3,         32'd5,        64'd15,                  1'b0});
        vt.push_back('{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1});
        vt.push_back('{32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 1'b0});
        vt.push_back('{32'h8000_0000, 32'd1,        64'h0000_0000_8000_0000, 1'b0});
        vt.push_back('{32'h1234_5678, 32'd0,        64'h0,                   1'b0});
        vt.push_back('{32'd1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0});
`endif

        // Reset state, with start already requested before release.
        reset = 1'b1;
        start = 1'b1;
        A = 32'd1023;
        B = 32'd50;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_P", P, 0);
        chk("reset_ok", ok, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        run(32'd1023, 32'd50, 64'd51150, 1'b0, "held_start_1023x50");

        for (int i = 0; i < vt.size(); i++) begin
            run(vt[i].a, vt[i].b, vt[i].p, vt[i].e, $sformatf("vec%0d", i));
        end

        // Reset in the middle of BUSY aborts with no partial result.
        A = 32'd7;
        B = 32'd9;
        start = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_P", P, 0);
        chk("midreset_ok", ok, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_err", err, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_busy_held", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        run(32'd7, 32'd9, 64'd63, 1'b0, "after_reset_7x9");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multiply.md
MULTIPLY -- requirements
Module: multiply

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: level request to begin a multiply.
REQ-005 The block SHALL have port A, input, WIDTH bits: multiplicand.
REQ-006 The block SHALL have port B, input, WIDTH bits: multiplier.
REQ-007 The block SHALL have port P, output, 2*WIDTH bits: full product, registered.
REQ-008 The block SHALL have port ok, output, 1 bit: P valid, result held.
REQ-009 The block SHALL have port busy, output, 1 bit: iteration in progress.
REQ-010 The block SHALL have port err, output, 1 bit: the product does not fit in WIDTH bits; valid only while ok=1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture A and B, clear the accumulator and the iteration counter, and enter BUSY.
REQ-013 In IDLE with start=0, the block SHALL hold P, ok and err unchanged, except that a new capture clears ok and err.
REQ-014 In BUSY, each cycle SHALL process one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand into the 2*WIDTH-bit accumulator, then shift.
REQ-015 All additions SHALL be 2*WIDTH bits wide, so no intermediate overflow can occur.
REQ-016 BUSY SHALL last exactly WIDTH cycles; on the WIDTH-th BUSY edge, P SHALL load the final product and the FSM SHALL enter DONE.
REQ-017 Latency SHALL be fixed: if capture occurs at edge k, ok SHALL be high after edge k+WIDTH, independent of operand values, including zero operands.
REQ-018 busy SHALL be 1 exactly while the state is BUSY.
REQ-019 ok SHALL be 1 exactly while the state is DONE.
REQ-020 err SHALL be registered with P: 1 if P[2*WIDTH-1:WIDTH] is nonzero (unsigned), otherwise 0.
REQ-021 In DONE, the block SHALL remain in DONE while start=1, so a held start SHALL NOT retrigger.
REQ-022 In DONE, start=0 SHALL return the FSM to IDLE; P and err SHALL hold, and ok SHALL fall.
REQ-023 start, A and B changes during BUSY SHALL be ignored; the captured operands SHALL be used.
REQ-024 P SHALL NOT change during BUSY; it SHALL update only on the final BUSY edge.

Reset
REQ-025 While reset=1, immediately and independent of clk, state SHALL be IDLE, and P=0, ok=0, busy=0, err=0, with the accumulator and counter cleared.
REQ-026 A reset asserted mid-BUSY SHALL abort the operation; no partial result SHALL appear on P.
REQ-027 After reset deasserts, a start already held high SHALL be captured at the first rising edge.

Configuration
REQ-028 The block SHALL support one compile-time option, macro MULT_SIGNED_EN.
REQ-029 With MULT_SIGNED_EN undefined, A, B and P SHALL be unsigned, and err SHALL follow REQ-020.
REQ-030 With MULT_SIGNED_EN defined, A and B SHALL be two's complement. The block SHALL multiply magnitudes and apply the sign of A XOR B when loading P, with latency unchanged.
REQ-031 With MULT_SIGNED_EN defined, err SHALL be 1 when P is not representable as a signed WIDTH-bit value, i.e. when the upper half is not the sign extension of P[WIDTH-1].

Verification
REQ-032 The bench SHALL apply A=1023, B=50 with start held high after reset, and SHALL check P=51150, err=0, ok exactly 32 cycles after capture, and ok staying high while start=1.
REQ-033 The bench SHALL apply A=0xFFFFFFFF, B=0xFFFFFFFF, unsigned, and SHALL check P=0xFFFFFFFE00000001 and err=1.
REQ-034 The bench SHALL apply A=0, B=0x12345678, and SHALL check P=0, err=0, with the same 32-cycle latency.
REQ-035 The bench SHALL start A=7, B=9, assert reset at BUSY cycle 10, and SHALL check P=0, ok=0, busy=0 immediately; after release with start high, it SHALL check P=63.
REQ-036 The bench SHALL drop start in DONE, then raise it with A=3, B=5, and SHALL check that ok falls, busy rises on the next edge, and P=15 on completion.
REQ-037 With MULT_SIGNED_EN defined, the bench SHALL apply A=-3, B=7 and check P=0xFFFFFFFFFFFFFFEB, err=0; it SHALL then apply A=0x40000000, B=4 and check err=1.
